// File: rtl/bram_mc.sv
// Multi-channel simple-dual-port block RAM with a post-reset clear engine, a read-valid flag and a
// selectable read-during-write policy. Define BRAM_OUTREG_EN to add a second output register (latency 2).
module bram_mc #(
   parameter int RAM_WIDTH   = 13,
   parameter int NB_ADDRESS  = 10,
   parameter int N_CHANNELS  = 3,
   parameter int WRITE_FIRST = 0
) (
   input  logic                            i_CLK,
   input  logic                            i_RST,
   input  logic [N_CHANNELS-1:0]           i_wrEnable,
   input  logic [NB_ADDRESS-1:0]           i_writeAdd,
   input  logic [N_CHANNELS*RAM_WIDTH-1:0] i_data,
   input  logic                            i_rdEnable,
   input  logic [NB_ADDRESS-1:0]           i_readAdd,
   output logic [N_CHANNELS*RAM_WIDTH-1:0] o_data,
   output logic                            o_valid,
   output logic                            o_ready
);

   localparam int DEPTH = 2**NB_ADDRESS;
   localparam int DW    = N_CHANNELS*RAM_WIDTH;
   localparam logic [NB_ADDRESS-1:0] LAST_ADDR = '1;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                  state, state_nxt;
   logic [NB_ADDRESS-1:0]   cnt, cnt_nxt;
   logic                    clr_we;
   logic                    rd_req;
   logic [N_CHANNELS-1:0]   byp;

   logic [RAM_WIDTH-1:0]    mem [N_CHANNELS][DEPTH];

   logic [DW-1:0]           rd_p0;
   logic                    vld_p0;

   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      rd_req    = 1'b0;
      case (state)
         CLEAR: begin
            clr_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_ADDR)
               state_nxt = RUN;
         end
         RUN: begin
            rd_req = i_rdEnable;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Same-address bypass only exists in write-first mode; read-first falls through to the stored word.
   always_comb begin
      for (int k = 0; k < N_CHANNELS; k++)
         byp[k] = (WRITE_FIRST != 0) && i_wrEnable[k] && (i_writeAdd == i_readAdd);
   end

   // Array write port: clear engine owns the port in CLEAR, user enables in RUN, nothing during reset.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         for (int k = 0; k < N_CHANNELS; k++) begin
            if (clr_we)
               mem[k][cnt] <= '0;
            else if (i_wrEnable[k])
               mem[k][i_writeAdd] <= i_data[k*RAM_WIDTH +: RAM_WIDTH];
         end
      end
   end

   // Stage p0: array read register
   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         rd_p0  <= '0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= rd_req;
         if (rd_req) begin
            for (int k = 0; k < N_CHANNELS; k++)
               rd_p0[k*RAM_WIDTH +: RAM_WIDTH] <= byp[k] ? i_data[k*RAM_WIDTH +: RAM_WIDTH]
                                                         : mem[k][i_readAdd];
         end
      end
   end

`ifdef BRAM_OUTREG_EN
   logic [DW-1:0] rd_p1;
   logic          vld_p1;

   // Stage p1: optional output register, holds its word until the next completed read
   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         rd_p1  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0)
            rd_p1 <= rd_p0;
      end
   end

   assign o_data  = rd_p1;
   assign o_valid = vld_p1;
`else
   assign o_data  = rd_p0;
   assign o_valid = vld_p0;
`endif

   assign o_ready = (state == RUN);

endmodule
